// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the seven-segment scan driver.
package seg_pkg;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF = 4'hF;
    typedef logic [1:0] digit_t;
    typedef enum logic {BLANK, ON} scan_state_t;
endpackage

// File: rtl/seg_scan_driver_mux.sv
// MUX: 4:1 selector of 7-bit segment patterns.
module MUX
    import seg_pkg::*;
(
    input  digit_t     S,
    input  logic [6:0] A,
    input  logic [6:0] B,
    input  logic [6:0] C,
    input  logic [6:0] D,
    output logic [6:0] Y
);
    always_comb Y = (S == 2'd0) ? A : (S == 2'd1) ? B : (S == 2'd2) ? C : D;
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: four-digit multiplexed 7-segment scanner with blanking
// and frame-synchronous double-buffered digit data.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [6:0] d0,
    input  logic [6:0] d1,
    input  logic [6:0] d2,
    input  logic [6:0] d3,
    output logic [6:0] seg_o,
    output logic [3:0] an_o,
    output logic [1:0] sel_o,
    output logic       frame_o
);
    localparam int CW = $clog2(CLK_DIV);

    if (BLANK_CYCLES < 1 || CLK_DIV < BLANK_CYCLES + 2) begin : g_param_check
        $error("seg_scan_driver: need BLANK_CYCLES>=1 and CLK_DIV>=BLANK_CYCLES+2");
    end

    logic [CW-1:0]   cnt, cnt_nxt;
    digit_t          idx;
    scan_state_t     state;
    logic [3:0][6:0] shadow, active;
    logic            pending, live, en_q;
    logic            slot_end, wrap, commit;
    logic [6:0]      mux_seg;

    assign slot_end = cnt == CW'(CLK_DIV - 1);
    assign wrap     = en && slot_end && idx == 2'd3;
    // Rising en restarts the scan and doubles as a commit point.
    assign commit   = pending && (wrap || (en && !en_q));
    assign cnt_nxt  = (!en || slot_end) ? '0 : cnt + 1'b1;
    assign sel_o    = idx;

    MUX u_mux (
        .S(idx),
        .A(active[0]),
        .B(active[1]),
        .C(active[2]),
        .D(active[3]),
        .Y(mux_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            idx     <= '0;
            state   <= BLANK;
            shadow  <= {4{SEG_BLANK}};
            active  <= {4{SEG_BLANK}};
            pending <= 1'b0;
            live    <= 1'b0;
            en_q    <= 1'b0;
            frame_o <= 1'b0;
            an_o    <= AN_OFF;
            seg_o   <= SEG_BLANK;
        end else begin
            cnt     <= cnt_nxt;
            idx     <= !en ? 2'd0 : slot_end ? idx + 2'd1 : idx;
            state   <= (cnt_nxt >= CW'(BLANK_CYCLES)) ? ON : BLANK;
            en_q    <= en;
            frame_o <= wrap;
            if (load) shadow <= {d3, d2, d1, d0};
            if (commit) active <= shadow;
            pending <= load || (pending && !commit);
            live    <= live || commit;
            // Anodes stay dark until the first committed frame after reset.
            an_o    <= (en && state == ON && live) ? ~(4'b0001 << idx) : AN_OFF;
            seg_o   <= (en && state == ON && live) ? mux_seg : SEG_BLANK;
        end
    end
endmodule
